// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths and opcode constants for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_NOP   = 6'b111111;

  // Opcodes that actually read rt as a source (addi/lw only write it)
  function automatic logic uses_rt(input logic [OPC_W-1:0] opc);
    return (opc == OP_RTYPE) || (opc == OP_BEQ) || (opc == OP_SW);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_operand_fwd_mux.sv
// Four-source operand select: ALU bypass, mem bypass, write-back bypass, register file.
module operand_fwd_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic [REG_W-1:0]  reg_num,
  input  logic              alu_sel,
  input  logic              mem_sel,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wnum,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] operand_c
);

  // r0 is hard-wired zero regardless of any bypass request
  always_comb begin
    operand_c = rf_data;
    if (reg_num == '0)
      operand_c = '0;
    else if (alu_sel)
      operand_c = alu_data;
    else if (mem_sel)
      operand_c = mem_data;
    else if (wb_en && (wnum == reg_num))
      operand_c = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Resolves step-2 source operands, detects load-use hazards and fills the ID/EX register.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W     = id_ex_operand_stage_pkg::DATA_W,
  parameter int unsigned REG_W      = id_ex_operand_stage_pkg::REG_W,
  parameter logic [5:0]  NOP_OPCODE = id_ex_operand_stage_pkg::OP_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode_step_2,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rt_rd_step_2,
  input  logic [DATA_W-1:0] imm_step_2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              is_send_from_alu_rs,
  input  logic              is_send_from_alu_rt,
  input  logic              is_send_from_mem_rs,
  input  logic              is_send_from_mem_rt,
  input  logic [DATA_W-1:0] alu_result_step_3,
  input  logic [DATA_W-1:0] mem_rdata_step_4,
  input  logic              is_write_reg,
  input  logic [REG_W-1:0]  wnum,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              stall,
  output logic [5:0]        opcode_step_3,
  output logic [DATA_W-1:0] op_a_step_3,
  output logic [DATA_W-1:0] op_b_step_3,
  output logic [DATA_W-1:0] imm_step_3,
  output logic [REG_W-1:0]  rt_rd_step_3,
  output logic [15:0]       stall_count
);

  import id_ex_operand_stage_pkg::*;

  logic              lw_step_3;
  logic              load_use_c;
  logic              bubble_c;
  logic [DATA_W-1:0] op_a_c;
  logic [DATA_W-1:0] op_b_c;

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .reg_num   (rs),
    .alu_sel   (is_send_from_alu_rs),
    .mem_sel   (is_send_from_mem_rs),
    .wb_en     (is_write_reg),
    .wnum      (wnum),
    .alu_data  (alu_result_step_3),
    .mem_data  (mem_rdata_step_4),
    .wb_data   (wdata),
    .rf_data   (rdata1),
    .operand_c (op_a_c)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .reg_num   (rt),
    .alu_sel   (is_send_from_alu_rt),
    .mem_sel   (is_send_from_mem_rt),
    .wb_en     (is_write_reg),
    .wnum      (wnum),
    .alu_data  (alu_result_step_3),
    .mem_data  (mem_rdata_step_4),
    .wb_data   (wdata),
    .rf_data   (rdata2),
    .operand_c (op_b_c)
  );

  // A load in step 3 has no data yet; a dependent step-2 instruction must wait one cycle
  always_comb begin
    load_use_c = 1'b0;
    if (lw_step_3 && (rt_rd_step_3 != '0)) begin
      load_use_c = (rs == rt_rd_step_3) ||
                   ((rt == rt_rd_step_3) && uses_rt(opcode_step_2));
    end
  end

  assign stall    = rst && load_use_c && !flush;
  assign bubble_c = flush || stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_step_3 <= NOP_OPCODE;
      op_a_step_3   <= '0;
      op_b_step_3   <= '0;
      imm_step_3    <= '0;
      rt_rd_step_3  <= '0;
      lw_step_3     <= 1'b0;
    end else if (bubble_c) begin
      opcode_step_3 <= NOP_OPCODE;
      op_a_step_3   <= '0;
      op_b_step_3   <= '0;
      imm_step_3    <= '0;
      rt_rd_step_3  <= '0;
      lw_step_3     <= 1'b0;
    end else begin
      opcode_step_3 <= opcode_step_2;
      op_a_step_3   <= op_a_c;
      op_b_step_3   <= op_b_c;
      imm_step_3    <= imm_step_2;
      rt_rd_step_3  <= rt_rd_step_2;
      lw_step_3     <= (opcode_step_2 == OP_LW);
    end
  end

  // Saturating load-use stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_count <= '0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with an expected-result queue.
module tb_id_ex_operand_stage;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_NOP   = 6'b111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode_step_2;
  logic [4:0]  rs, rt, rt_rd_step_2;
  logic [31:0] imm_step_2, rdata1, rdata2;
  logic        is_send_from_alu_rs, is_send_from_alu_rt;
  logic        is_send_from_mem_rs, is_send_from_mem_rt;
  logic [31:0] alu_result_step_3, mem_rdata_step_4;
  logic        is_write_reg;
  logic [4:0]  wnum;
  logic [31:0] wdata;
  logic        flush;
  logic        stall;
  logic [5:0]  opcode_step_3;
  logic [31:0] op_a_step_3, op_b_step_3, imm_step_3;
  logic [4:0]  rt_rd_step_3;
  logic [15:0] stall_count;

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   step_no = 0;

  id_ex_operand_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .opcode_step_2       (opcode_step_2),
    .rs                  (rs),
    .rt                  (rt),
    .rt_rd_step_2        (rt_rd_step_2),
    .imm_step_2          (imm_step_2),
    .rdata1              (rdata1),
    .rdata2              (rdata2),
    .is_send_from_alu_rs (is_send_from_alu_rs),
    .is_send_from_alu_rt (is_send_from_alu_rt),
    .is_send_from_mem_rs (is_send_from_mem_rs),
    .is_send_from_mem_rt (is_send_from_mem_rt),
    .alu_result_step_3   (alu_result_step_3),
    .mem_rdata_step_4    (mem_rdata_step_4),
    .is_write_reg        (is_write_reg),
    .wnum                (wnum),
    .wdata               (wdata),
    .flush               (flush),
    .stall               (stall),
    .opcode_step_3       (opcode_step_3),
    .op_a_step_3         (op_a_step_3),
    .op_b_step_3         (op_b_step_3),
    .imm_step_3          (imm_step_3),
    .rt_rd_step_3        (rt_rd_step_3),
    .stall_count         (stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s step%0d: observed %h expected %h", tag, step_no, obs, exp);
  endtask

  task automatic clear_inputs();
    opcode_step_2 = OP_RTYPE; rs = '0; rt = '0; rt_rd_step_2 = '0;
    imm_step_2 = '0; rdata1 = '0; rdata2 = '0;
    is_send_from_alu_rs = 1'b0; is_send_from_alu_rt = 1'b0;
    is_send_from_mem_rs = 1'b0; is_send_from_mem_rt = 1'b0;
    alu_result_step_3 = '0; mem_rdata_step_4 = '0;
    is_write_reg = 1'b0; wnum = '0; wdata = '0; flush = 1'b0;
  endtask

  // Check combinational stall, queue the expected ID/EX contents, clock, then compare
  task automatic step(input logic exp_stall, input logic [5:0] opc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic [4:0] dst,
                      input logic [15:0] cnt);
    exp_t e;
    step_no++;
    #1;
    check("stall", 32'(stall), 32'(exp_stall));
    e.opc = opc; e.a = a; e.b = b; e.imm = imm; e.dst = dst; e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("opcode", 32'(opcode_step_3), 32'(e.opc));
    check("op_a", op_a_step_3, e.a);
    check("op_b", op_b_step_3, e.b);
    check("imm", imm_step_3, e.imm);
    check("rt_rd", 32'(rt_rd_step_3), 32'(e.dst));
    check("stall_count", 32'(stall_count), 32'(e.cnt));
  endtask

  task automatic lw(input logic [4:0] dst, input logic [15:0] cnt);
    clear_inputs();
    opcode_step_2 = OP_LW; rs = 5'd1; rt = dst; rt_rd_step_2 = dst;
    imm_step_2 = 32'd4; rdata1 = 32'h100;
    step(1'b0, OP_LW, 32'h100, 32'h0, 32'd4, dst, cnt);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_opcode", 32'(opcode_step_3), 32'(OP_NOP));
    check("reset_op_a", op_a_step_3, 32'h0);
    check("reset_op_b", op_b_step_3, 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_count", 32'(stall_count), 32'h0);
    rst = 1'b1;

    // ALU bypass beats the register file
    clear_inputs();
    rs = 5'd5; rt = 5'd6; rt_rd_step_2 = 5'd7; rdata1 = 32'hDEAD; rdata2 = 32'h2;
    is_send_from_alu_rs = 1'b1; alu_result_step_3 = 32'h1234;
    step(1'b0, OP_RTYPE, 32'h1234, 32'h2, 32'h0, 5'd7, 16'd0);

    // Bypass priority on rt: ALU, then mem, then write-back
    clear_inputs();
    rs = 5'd1; rt = 5'd2; rt_rd_step_2 = 5'd8; rdata1 = 32'h11; rdata2 = 32'h22;
    is_send_from_alu_rt = 1'b1; alu_result_step_3 = 32'hA;
    is_send_from_mem_rt = 1'b1; mem_rdata_step_4 = 32'hB;
    is_write_reg = 1'b1; wnum = 5'd2; wdata = 32'hC; imm_step_2 = 32'h5;
    step(1'b0, OP_RTYPE, 32'h11, 32'hA, 32'h5, 5'd8, 16'd0);
    is_send_from_alu_rt = 1'b0;
    step(1'b0, OP_RTYPE, 32'h11, 32'hB, 32'h5, 5'd8, 16'd0);
    is_send_from_mem_rt = 1'b0;
    step(1'b0, OP_RTYPE, 32'h11, 32'hC, 32'h5, 5'd8, 16'd0);

    // Load-use on rs: one bubble, then mem bypass
    lw(5'd3, 16'd0);
    clear_inputs();
    rs = 5'd3; rt = 5'd4; rt_rd_step_2 = 5'd9; rdata1 = 32'h99; rdata2 = 32'h44;
    step(1'b1, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 16'd1);
    is_send_from_mem_rs = 1'b1; mem_rdata_step_4 = 32'h55;
    step(1'b0, OP_RTYPE, 32'h55, 32'h44, 32'h0, 5'd9, 16'd1);

    // Flush wins over a simultaneous hazard
    lw(5'd3, 16'd1);
    clear_inputs();
    rs = 5'd3; rt = 5'd4; rt_rd_step_2 = 5'd9; rdata1 = 32'h99; flush = 1'b1;
    step(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 16'd1);

    // rt hazard only for opcodes that read rt
    lw(5'd4, 16'd1);
    clear_inputs();
    opcode_step_2 = OP_ADDI; rs = 5'd1; rt = 5'd4; rt_rd_step_2 = 5'd4;
    rdata1 = 32'h7; imm_step_2 = 32'h3;
    step(1'b0, OP_ADDI, 32'h7, 32'h0, 32'h3, 5'd4, 16'd1);
    lw(5'd4, 16'd1);
    clear_inputs();
    opcode_step_2 = OP_SW; rs = 5'd1; rt = 5'd4; rdata1 = 32'h8; imm_step_2 = 32'h10;
    step(1'b1, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 16'd2);
    is_send_from_mem_rt = 1'b1; mem_rdata_step_4 = 32'h77;
    step(1'b0, OP_SW, 32'h8, 32'h77, 32'h10, 5'd0, 16'd2);

    // Back-to-back loads to a dependent base register
    lw(5'd5, 16'd2);
    clear_inputs();
    opcode_step_2 = OP_LW; rs = 5'd5; rt = 5'd6; rt_rd_step_2 = 5'd6; imm_step_2 = 32'h8;
    step(1'b1, OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 16'd3);
    is_send_from_mem_rs = 1'b1; mem_rdata_step_4 = 32'h200;
    step(1'b0, OP_LW, 32'h200, 32'h0, 32'h8, 5'd6, 16'd3);

    // Register zero ignores every bypass and never stalls
    clear_inputs();
    is_send_from_alu_rs = 1'b1; is_send_from_alu_rt = 1'b1; alu_result_step_3 = 32'hFFFF;
    rdata1 = 32'hDEAD; is_write_reg = 1'b1; wnum = 5'd0; wdata = 32'h7; rt_rd_step_2 = 5'd2;
    step(1'b0, OP_RTYPE, 32'h0, 32'h0, 32'h0, 5'd2, 16'd3);
    lw(5'd0, 16'd3);
    clear_inputs();
    rt_rd_step_2 = 5'd2;
    step(1'b0, OP_RTYPE, 32'h0, 32'h0, 32'h0, 5'd2, 16'd3);

    // Reset asserted mid-stall
    lw(5'd3, 16'd3);
    clear_inputs();
    rs = 5'd3;
    #1;
    step_no++;
    check("pre_reset_stall", 32'(stall), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_stall", 32'(stall), 32'h0);
    check("midreset_opcode", 32'(opcode_step_3), 32'(OP_NOP));
    check("midreset_rt_rd", 32'(rt_rd_step_3), 32'h0);
    check("midreset_count", 32'(stall_count), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Consumer side of the decode-stage forwarding/control decisions.
- Takes the step-2 instruction, resolves its source operands, and registers the result into the step-3 (ID/EX) pipeline register.
- Operand sources are: ALU bypass from step 3, memory bypass from step 4, write-back bypass from step 5, or the register file.
- Detects load-use hazards, which forwarding cannot cover, and inserts a one-cycle bubble while stalling fetch/decode. Branch flush also inserts a bubble.

Parameters:
DATA_W, 32, operand/result width
REG_W, 5, register number width
NOP_OPCODE, 6'b111111, opcode injected for bubbles (writes nothing, matches no forwarding opcode)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode_step_2  in  6  decoded opcode in step 2
rs  in  REG_W  source register 1 in step 2
rt  in  REG_W  source register 2 in step 2
rt_rd_step_2  in  REG_W  destination after rt/rd mux in step 2
imm_step_2  in  DATA_W  sign-extended immediate
rdata1  in  DATA_W  register file read port 1 (rs)
rdata2  in  DATA_W  register file read port 2 (rt)
is_send_from_alu_rs / is_send_from_alu_rt  in  1 each  step-3 ALU bypass requests
is_send_from_mem_rs / is_send_from_mem_rt  in  1 each  step-4 load bypass requests
alu_result_step_3  in  DATA_W  current ALU output
mem_rdata_step_4  in  DATA_W  current load data
is_write_reg  in  1  step-5 write enable
wnum  in  REG_W  step-5 write register
wdata  in  DATA_W  step-5 write data
flush  in  1  taken branch; kill step-2 instruction
stall  out  1  hold PC and IF/ID register this cycle (combinational)
opcode_step_3  out  6  registered opcode
op_a_step_3  out  DATA_W  registered resolved rs operand
op_b_step_3  out  DATA_W  registered resolved rt operand
imm_step_3  out  DATA_W  registered immediate
rt_rd_step_3  out  REG_W  registered destination
stall_count  out  16  saturating count of load-use stall cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - opcode_step_3 = NOP_OPCODE; all data/destination outputs = 0.
  - stall_count = 0; internal lw-tracking register = 0.
  - stall output is 0 while in reset.
- Load-use hazard, evaluated combinationally:
  - Condition: registered opcode_step_3 == 6'b100011 (lw), AND rt_rd_step_3 != 0, AND (rs == rt_rd_step_3 OR (rt == rt_rd_step_3 AND opcode_step_2 ∈ {000000, 000100, 101011})).
  - When the condition holds, stall = 1 and flush = 0.
- Operand resolution, per source:
  - If the register number is 0, the operand is 0.
  - Otherwise the first matching source wins, in this order: ALU bypass (alu_result_step_3), mem bypass (mem_rdata_step_4), write-back bypass (is_write_reg && wnum == reg → wdata), register file.
- Clock edge, mutually exclusive cases in priority order:
  - flush=1: load a bubble (opcode NOP_OPCODE, operands/imm/dest 0). stall is forced to 0 that cycle. Flush wins over a simultaneous hazard.
  - stall=1: load a bubble; the upstream step-2 instruction is held by the pipeline. stall_count += 1, saturating at 16'hFFFF.
  - otherwise: load the resolved operands and the step-2 fields.
- Stall length: exactly one cycle per load-use pair.
  - The next cycle the lw sits in step 4 and the mem bypass supplies the data.
  - The hazard cannot retrigger, because step 3 then holds the bubble.
- Back-to-back loads: lw followed by lw to the same register produces one stall, then forwarding via mem.
- Latency: one cycle from step-2 inputs to step-3 outputs. No combinational path from inputs to the step-3 outputs.
- Reset asserted mid-stall: the bubble is abandoned and outputs return to reset values. stall drops immediately.

Decomposition:
- Shared package: opcode constants (OP_RTYPE 000000, OP_ADDI 001000, OP_BEQ 000100, OP_LW 100011, OP_SW 101011, OP_NOP 111111), DATA_W and REG_W.
- One sub-module, operand_fwd_mux: a combinational 4-source priority select with a zero-register guard. It is instantiated twice, once for rs and once for rt.

Test Plan:
1. Reset: hold rst=0 for 2 cycles → opcode_step_3=6'b111111, op_a/op_b=0, stall=0, stall_count=0.
2. ALU bypass: step 2 is add with rs=5; is_send_from_alu_rs=1, alu_result_step_3=32'h1234, rdata1=32'hDEAD → op_a_step_3=32'h1234 after the edge.
3. Priority: all of is_send_from_alu_rt=1 (0xA), is_send_from_mem_rt=1 (0xB), and write-back to rt (0xC) are active → op_b=0xA. Drop the ALU request → 0xB. Drop the mem request → 0xC.
4. Load-use: lw r3 in step 3, then step-2 add with rs=3:
   - stall=1 for exactly 1 cycle; opcode_step_3 = NOP; stall_count=1.
   - Next cycle: mem bypass with mem_rdata_step_4=32'h55 gives op_a=32'h55.
5. Flush during hazard: same setup as 4 plus flush=1 → stall=0, bubble loaded, stall_count unchanged.
6. Register zero: rs=0 with is_send_from_alu_rs=1 and alu_result_step_3=32'hFFFF → op_a=0. Also lw r0 followed by a consumer of r0 → no stall.
